// File: rtl/detect_count_display.sv
// detect_count_display: counts sequence-detector matches as 4 BCD digits and scans them onto a 4-digit 7-segment display.
// Define SATURATE_EN to hold the count at 9999 at the limit instead of wrapping to 0000.
module detect_count_display #(
    parameter int REFRESH_DIV = 100_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       step,
    input  logic       y_in,
    input  logic       clr,
    output logic [3:0] an,
    output logic [6:0] seg,
    output logic       dp,
    output logic       ovf
);
    localparam int CW = REFRESH_DIV > 1 ? $clog2(REFRESH_DIV) : 1;
    localparam logic [CW-1:0] RLAST = CW'(REFRESH_DIV - 1);

    logic             step_q, y_q, hit, carry, at_max;
    logic [3:0][3:0]  d, d_inc, d_evt;
    logic [3:0]       blank;
    logic [CW-1:0]    rcnt;
    logic [1:0]       sel;

    function automatic logic [6:0] seg_dec(input logic [3:0] v);
        case (v)
            4'd0: return 7'b1000000;
            4'd1: return 7'b1111001;
            4'd2: return 7'b0100100;
            4'd3: return 7'b0110000;
            4'd4: return 7'b0011001;
            4'd5: return 7'b0010010;
            4'd6: return 7'b0000010;
            4'd7: return 7'b1111000;
            4'd8: return 7'b0000000;
            4'd9: return 7'b0010000;
            default: return 7'b1111111;
        endcase
    endfunction

    // match is sampled the cycle before the detector's state advances
    assign hit = step && !step_q && y_q;

    always_comb begin
        carry = 1'b1;
        d_inc = d;
        for (int i = 0; i < 4; i++) begin
            d_inc[i] = carry ? (d[i] == 4'd9 ? 4'd0 : d[i] + 4'd1) : d[i];
            carry    = carry && d[i] == 4'd9;
        end
        at_max = carry;
    end

`ifdef SATURATE_EN
    assign d_evt = at_max ? d : d_inc;
`else
    assign d_evt = d_inc;
`endif

    always_comb begin
        blank[3] = d[3] == 4'd0;
        blank[2] = blank[3] && d[2] == 4'd0;
        blank[1] = blank[2] && d[1] == 4'd0;
        blank[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            step_q <= 1'b0;
            y_q    <= 1'b0;
            d      <= '0;
            ovf    <= 1'b0;
            rcnt   <= '0;
            sel    <= 2'd0;
            an     <= 4'b1111;
            seg    <= 7'b1111111;
            dp     <= 1'b1;
        end else begin
            step_q <= step;
            y_q    <= y_in;
            if (clr) begin
                d <= '0;
            end else if (hit) begin
                d <= d_evt;
                if (at_max) ovf <= 1'b1;
            end
            rcnt <= rcnt == RLAST ? '0 : rcnt + CW'(1);
            if (rcnt == RLAST) sel <= sel + 2'd1;
            an  <= ~(4'b0001 << sel);
            seg <= blank[sel] ? 7'b1111111 : seg_dec(d[sel]);
            dp  <= !(sel == 2'd0 && ovf);
        end
    end
endmodule
